// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32I-subset datapath: fetch, decode, execute,
// memory and writeback, with a req/ready memory handshake and a wait timeout.
module multicycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic [6:0]             opcode,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   i_or_d,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   pc_source,
  output logic [1:0]             alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic                   reg_write,
  output logic                   mem_to_reg,
  output logic [3:0]             state,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] instr_retired
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC      = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_ERROR     = 4'd9;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int              WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [3:0]             state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   error_q, error_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  logic                   retire;
  logic                   timeout;

  // The zero flag gates pc_write_cond inside the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    retire        = 1'b0;
    state_d       = state_q;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b11;
        case (opcode)
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_RTYPE, OP_ITYPE: state_d = S_EXEC;
          OP_BRANCH:          state_d = S_BRANCH;
          default:            state_d = S_ERROR;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        if (opcode == OP_LOAD)       state_d = S_MEM_READ;
        else if (opcode == OP_STORE) state_d = S_MEM_WRITE;
        else                         state_d = S_ERROR;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 2'b01;
        alu_src_b = (opcode == OP_ITYPE) ? 2'b10 : 2'b00;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b01;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = S_ERROR;
    endcase

    // A ready on the limit cycle wins; otherwise the stalled access aborts.
    timeout = mem_req && !mem_ready && (wait_q == WAIT_LIMIT);
    if (timeout) state_d = S_ERROR;

    wait_d    = (mem_req && !mem_ready && !timeout) ? wait_q + WAIT_W'(1) : '0;
    retired_d = retire ? retired_q + COUNT_WIDTH'(1) : retired_q;
    error_d   = error_q || (state_d == S_ERROR);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      error_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      error_q   <= error_d;
      retired_q <= retired_d;
    end
  end

  assign state         = state_q;
  assign error         = error_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a per-cycle vector table plus
// hand-written sequences for error, timeout, counter wrap and mid-access reset.
module tb_multicycle_sequencer;

  localparam int CW = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
  //  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, error}
  localparam logic [15:0] C_IDLE    = 16'h0000;
  localparam logic [15:0] C_FETCH_W = 16'h8020;
  localparam logic [15:0] C_FETCH_R = 16'h9820;
  localparam logic [15:0] C_DEC     = 16'h0160;
  localparam logic [15:0] C_MADDR   = 16'h00C0;
  localparam logic [15:0] C_MREAD   = 16'hA000;
  localparam logic [15:0] C_MWB     = 16'h0006;
  localparam logic [15:0] C_MWRITE  = 16'hE000;
  localparam logic [15:0] C_EXEC_R  = 16'h0090;
  localparam logic [15:0] C_EXEC_I  = 16'h00D0;
  localparam logic [15:0] C_ALUWB   = 16'h0004;
  localparam logic [15:0] C_BR      = 16'h0688;
  localparam logic [15:0] C_ERR     = 16'h0001;

  typedef struct {
    logic          run;
    logic [6:0]    op;
    logic          zero;
    logic          rdy;
    logic [3:0]    expState;
    logic [15:0]   expCtrl;
    logic [CW-1:0] expRet;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic          zero = 1'b0;
  logic          memReady = 1'b0;
  logic          memReq, memWe, iOrD, irWrite, pcWrite, pcWriteCond, pcSource;
  logic [1:0]    aluSrcA, aluSrcB, aluOp;
  logic          regWrite, memToReg, errorO;
  logic [3:0]    stateO;
  logic [CW-1:0] retired;
  logic [15:0]   ctrlObs;

  int nApplied = 0;
  int nMiscompares = 0;
  vec_t vecs[32];

  always #5 clock = ~clock;

  multicycle_sequencer #(.TIMEOUT_CYCLES(4), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(memReady), .mem_req(memReq), .mem_we(memWe), .i_or_d(iOrD),
    .ir_write(irWrite), .pc_write(pcWrite), .pc_write_cond(pcWriteCond),
    .pc_source(pcSource), .alu_src_a(aluSrcA), .alu_src_b(aluSrcB),
    .alu_op(aluOp), .reg_write(regWrite), .mem_to_reg(memToReg),
    .state(stateO), .error(errorO), .instr_retired(retired)
  );

  assign ctrlObs = {memReq, memWe, iOrD, irWrite, pcWrite, pcWriteCond, pcSource,
                    aluSrcA, aluSrcB, aluOp, regWrite, memToReg, errorO};

  function automatic vec_t mk(input logic r, input logic [6:0] o, input logic z,
                              input logic rd, input logic [3:0] s,
                              input logic [15:0] c, input logic [CW-1:0] n);
    vec_t v;
    v.run = r; v.op = o; v.zero = z; v.rdy = rd;
    v.expState = s; v.expCtrl = c; v.expRet = n;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic [6:0] o,
                               input logic z, input logic rd);
    @(negedge clock);
    run = r; opcode = o; zero = z; memReady = rd;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] s,
                             input logic [15:0] c, input logic [CW-1:0] n);
    nApplied++;
    if (stateO !== s || ctrlObs !== c || retired !== n) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got state=%0d ctrl=%h retired=%0d, want state=%0d ctrl=%h retired=%0d",
               name, stateO, ctrlObs, retired, s, c, n);
    end
  endtask

  task automatic pulseReset(input int n);
    @(negedge clock);
    reset = 1'b0; run = 1'b0; memReady = 1'b0;
    repeat (n) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic runInstr(input logic [6:0] o);
    repeat (4) applyStimulus(1'b1, o, 1'b0, 1'b1);
  endtask

  initial begin
    vecs[0]  = mk(1, OP_RTYPE,  0, 1, 0, C_FETCH_R, 0);
    vecs[1]  = mk(1, OP_RTYPE,  0, 1, 1, C_DEC,     0);
    vecs[2]  = mk(1, OP_RTYPE,  0, 1, 6, C_EXEC_R,  0);
    vecs[3]  = mk(1, OP_RTYPE,  0, 1, 7, C_ALUWB,   0);
    vecs[4]  = mk(0, OP_RTYPE,  0, 1, 0, C_IDLE,    1);
    vecs[5]  = mk(0, OP_RTYPE,  0, 1, 0, C_IDLE,    1);
    vecs[6]  = mk(1, OP_ITYPE,  0, 1, 0, C_FETCH_R, 1);
    vecs[7]  = mk(1, OP_ITYPE,  0, 1, 1, C_DEC,     1);
    vecs[8]  = mk(1, OP_ITYPE,  0, 1, 6, C_EXEC_I,  1);
    vecs[9]  = mk(1, OP_ITYPE,  0, 1, 7, C_ALUWB,   1);
    vecs[10] = mk(1, OP_STORE,  0, 1, 0, C_FETCH_R, 2);
    vecs[11] = mk(1, OP_STORE,  0, 1, 1, C_DEC,     2);
    vecs[12] = mk(1, OP_STORE,  0, 1, 2, C_MADDR,   2);
    vecs[13] = mk(1, OP_STORE,  0, 1, 5, C_MWRITE,  2);
    vecs[14] = mk(1, OP_LOAD,   0, 0, 0, C_FETCH_W, 3);
    vecs[15] = mk(1, OP_LOAD,   0, 0, 0, C_FETCH_W, 3);
    vecs[16] = mk(1, OP_LOAD,   0, 0, 0, C_FETCH_W, 3);
    vecs[17] = mk(1, OP_LOAD,   0, 1, 0, C_FETCH_R, 3);
    vecs[18] = mk(1, OP_LOAD,   0, 1, 1, C_DEC,     3);
    vecs[19] = mk(1, OP_LOAD,   0, 0, 2, C_MADDR,   3);
    vecs[20] = mk(1, OP_LOAD,   0, 0, 3, C_MREAD,   3);
    vecs[21] = mk(1, OP_LOAD,   0, 0, 3, C_MREAD,   3);
    vecs[22] = mk(1, OP_LOAD,   0, 0, 3, C_MREAD,   3);
    vecs[23] = mk(1, OP_LOAD,   0, 1, 3, C_MREAD,   3);
    vecs[24] = mk(1, OP_LOAD,   0, 0, 4, C_MWB,     3);
    vecs[25] = mk(1, OP_BRANCH, 1, 1, 0, C_FETCH_R, 4);
    vecs[26] = mk(1, OP_BRANCH, 1, 1, 1, C_DEC,     4);
    vecs[27] = mk(1, OP_BRANCH, 1, 1, 8, C_BR,      4);
    vecs[28] = mk(1, OP_BRANCH, 0, 1, 0, C_FETCH_R, 5);
    vecs[29] = mk(1, OP_BRANCH, 0, 1, 1, C_DEC,     5);
    vecs[30] = mk(1, OP_BRANCH, 0, 1, 8, C_BR,      5);
    vecs[31] = mk(0, OP_BRANCH, 0, 1, 0, C_IDLE,    6);

    pulseReset(2);
    checkOutput("reset_state", 4'd0, C_IDLE, '0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(vecs[i].run, vecs[i].op, vecs[i].zero, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expCtrl, vecs[i].expRet);
    end

    // Illegal opcode: sticky ERROR until reset.
    pulseReset(1);
    applyStimulus(1, OP_BAD, 0, 1); checkOutput("bad_fetch", 0, C_FETCH_R, 0);
    applyStimulus(1, OP_BAD, 0, 1); checkOutput("bad_decode", 1, C_DEC, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, OP_RTYPE, 1, 1);
      checkOutput($sformatf("err_hold%0d", i), 9, C_ERR, 0);
    end
    pulseReset(1);
    checkOutput("err_reset", 0, C_IDLE, 0);

    // Store that never completes times out after exactly four wait cycles.
    pulseReset(1);
    applyStimulus(1, OP_STORE, 0, 1); checkOutput("to_fetch", 0, C_FETCH_R, 0);
    applyStimulus(1, OP_STORE, 0, 1); checkOutput("to_decode", 1, C_DEC, 0);
    applyStimulus(1, OP_STORE, 0, 0); checkOutput("to_maddr", 2, C_MADDR, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, OP_STORE, 0, 0);
      checkOutput($sformatf("to_wait%0d", i), 5, C_MWRITE, 0);
    end
    applyStimulus(0, OP_STORE, 0, 0); checkOutput("to_error", 9, C_ERR, 0);

    // Ready on the limit cycle completes the store instead.
    pulseReset(1);
    applyStimulus(1, OP_STORE, 0, 1);
    applyStimulus(1, OP_STORE, 0, 1);
    applyStimulus(1, OP_STORE, 0, 0);
    repeat (3) applyStimulus(1, OP_STORE, 0, 0);
    applyStimulus(1, OP_STORE, 0, 1); checkOutput("race_last", 5, C_MWRITE, 0);
    applyStimulus(0, OP_STORE, 0, 0); checkOutput("race_done", 0, C_IDLE, 1);

    // Retired counter wraps at 4 bits.
    pulseReset(1);
    repeat (15) runInstr(OP_RTYPE);
    applyStimulus(0, OP_RTYPE, 0, 0); checkOutput("wrap_15", 0, C_IDLE, 4'd15);
    runInstr(OP_RTYPE);
    applyStimulus(0, OP_RTYPE, 0, 0); checkOutput("wrap_16", 0, C_IDLE, 4'd0);
    runInstr(OP_RTYPE);
    applyStimulus(0, OP_RTYPE, 0, 0); checkOutput("wrap_17", 0, C_IDLE, 4'd1);

    // Reset in the middle of a data read aborts it.
    applyStimulus(1, OP_LOAD, 0, 1);
    applyStimulus(1, OP_LOAD, 0, 1);
    applyStimulus(1, OP_LOAD, 0, 0);
    applyStimulus(1, OP_LOAD, 0, 0); checkOutput("mid_read", 3, C_MREAD, 4'd1);
    pulseReset(1);
    checkOutput("mid_read_reset", 0, C_IDLE, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the RV32I-subset datapath: fetch, decode, execute, memory and writeback, one instruction at a time.
- The datapath's PC, register file, ALU and a single shared instruction/data memory are reused across cycles.
- Drives every datapath mux and enable, and handshakes with the shared memory over req/ready.
- Replaces the single-cycle combinational control; the ALU control decoder (alu_op, funct3, funct7) is unchanged.

Parameters:
- TIMEOUT_CYCLES, 255: maximum consecutive wait cycles on one memory request before the block enters ERROR.
- COUNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (low at the rising edge of clock resets the block).
- run  in  1  permits a new fetch; sampled only in FETCH.
- opcode  in  7  IR[6:0], valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  shared memory completed the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; valid only while mem_req=1.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when zero=1.
- pc_source  out  1  PC input select: 0 = ALU result, 1 = ALUOut.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = rs1 reg, 10 = oldPC.
- alu_src_b  out  2  ALU B select: 00 = rs2 reg, 01 = constant 4, 10 = imm, 11 = imm<<1.
- alu_op  out  2  00 = add, 01 = sub, 10 = decode by funct fields.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- state  out  4  current state encoding, for debug.
- error  out  1  sticky fault flag.
- instr_retired  out  COUNT_WIDTH  retired-instruction counter.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC=6, ALU_WB=7, BRANCH=8, ERROR=9. Codes 10–15 are unreachable and map to ERROR.
- Reset (reset=0 at the clock edge):
  - state=FETCH, error=0, instr_retired=0, wait counter=0.
  - Reset overrides everything, including an in-flight memory access and the ERROR state.
- Control outputs are decoded from state, plus mem_ready and zero where noted. Any signal not listed for a state is 0.
- FETCH:
  - run=0: all outputs 0; hold FETCH.
  - run=1: mem_req=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00, ir_write=mem_ready, pc_write=mem_ready.
  - Go to DECODE on mem_ready=1.
- DECODE:
  - alu_src_a=10, alu_src_b=11, alu_op=00; the branch target is latched into ALUOut.
  - Next state by opcode: 0000011 or 0100011 → MEM_ADDR; 0110011 or 0010011 → EXEC; 1100011 → BRANCH; any other opcode → ERROR.
- MEM_ADDR:
  - alu_src_a=01, alu_src_b=10, alu_op=00.
  - Next state: load → MEM_READ, store → MEM_WRITE.
- MEM_READ: mem_req=1, i_or_d=1, mem_we=0; go to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=1; retire the instruction; go to FETCH.
- MEM_WRITE: mem_req=1, i_or_d=1, mem_we=1; on mem_ready, retire and go to FETCH.
- EXEC:
  - alu_src_a=01, alu_op=10.
  - alu_src_b=00 for opcode 0110011, 10 for opcode 0010011.
  - Go to ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0; retire; go to FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1; retire; go to FETCH.
- ERROR: all control outputs 0, error=1; held until reset.
- Memory handshake:
  - mem_req, mem_we and i_or_d stay stable until the cycle in which mem_ready=1.
  - The access completes in that cycle, and the FSM leaves the state at the next edge.
  - Zero-wait memory (mem_ready=1 in the first cycle) is legal.
  - mem_ready while mem_req=0 is ignored.
- Timeout:
  - The wait counter increments each cycle with mem_req=1 and mem_ready=0, and clears on mem_ready or on leaving the memory state.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready still 0, go to ERROR.
  - mem_ready=1 in the same cycle that the limit is hit wins: the access completes, no error.
- Retirement: instr_retired increments by 1 on each retire and wraps from all-ones to 0.
- CPI: R/I-type 4, load 5, store 4, branch 3, each plus memory wait cycles.

Test Plan:
- Reset low for 2 cycles, run=1, opcode=0110011, mem_ready always 1 → states 0,1,6,7,0; reg_write=1 only in ALU_WB; instr_retired=1 after 4 cycles.
- Load 0000011 with mem_ready delayed 3 cycles in both FETCH and MEM_READ → mem_req held stable for 4 cycles each; states 0,1,2,3,4; total 11 cycles; mem_to_reg=1 in MEM_WB.
- Branch 1100011 with zero=1, then zero=0 → pc_write_cond=1 and pc_source=1 in BRANCH both times; 3 cycles each; instr_retired +2.
- Opcode 1111111 in DECODE → state=9 and error=1 next cycle; all controls 0 for 20 cycles; reset low for 1 cycle → state=0, error=0.
- TIMEOUT_CYCLES=4, store with mem_ready never asserted → ERROR entered after exactly 4 wait cycles in MEM_WRITE; separately, mem_ready=1 on the 4th wait cycle → no error, state=0.
- COUNT_WIDTH=4, 17 R-type instructions → instr_retired wraps 15→0 and reads 1; reset asserted mid-MEM_READ → state=0 and mem_req=0 on the next cycle.
